// File: rtl/or3_sweep_tester.sv
// Self-test sequencer: sweeps all 3-bit codes into one OR/NOR gate-under-test,
// samples its output after a settle delay and accumulates mismatch results.
module or3_sweep_tester #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1,
    parameter string       ORDER         = "binary",
    parameter bit          INVERT        = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [2:0] dut_x,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_mask,
    output logic [7:0] err_count
);

    localparam int unsigned CW   = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned PW   = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam bit          GRAY = (ORDER == "gray");

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("or3_sweep_tester: SETTLE_CYCLES must be >= 1");
        end
        if (PASSES < 1) begin : g_bad_passes
            $error("or3_sweep_tester: PASSES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] settle_cnt;
    logic [2:0]    idx;
    logic [PW-1:0] pass_cnt;

    logic          exp_y_c;
    logic          mismatch_c;
    logic [7:0]    err_inc_c;
    logic [7:0]    err_after_c;

    // Map a sequence position to the code driven onto the GUT.
    function automatic logic [2:0] code_of(input logic [2:0] pos);
        return GRAY ? (pos ^ (pos >> 1)) : pos;
    endfunction

    // Case-equality compare so that x/z on the GUT output always counts as a miss.
    always_comb begin
        exp_y_c     = INVERT ? ~(|dut_x) : (|dut_x);
        mismatch_c  = (dut_y !== exp_y_c);
        err_inc_c   = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
        err_after_c = mismatch_c ? err_inc_c : err_count;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            idx        <= '0;
            pass_cnt   <= '0;
            dut_x      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= '0;
            err_count  <= '0;
        end else if (state != IDLE && abort) begin
            // Partial fail_mask/err_count are kept for inspection.
            state <= IDLE;
            dut_x <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    dut_x <= '0;
                    if (start && !abort) begin
                        state      <= SETTLE;
                        idx        <= '0;
                        pass_cnt   <= '0;
                        fail_mask  <= '0;
                        err_count  <= '0;
                        pass       <= 1'b0;
                        dut_x      <= code_of(3'd0);
                        settle_cnt <= CW'(SETTLE_CYCLES);
                        busy       <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == CW'(1)) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end
                end
                SAMPLE: begin
                    if (mismatch_c) begin
                        fail_mask[dut_x] <= 1'b1;
                    end
                    err_count <= err_after_c;
                    if (idx != 3'd7) begin
                        idx        <= idx + 3'd1;
                        dut_x      <= code_of(idx + 3'd1);
                        settle_cnt <= CW'(SETTLE_CYCLES);
                        state      <= SETTLE;
                    end else if (pass_cnt != PW'(PASSES - 1)) begin
                        pass_cnt   <= pass_cnt + PW'(1);
                        idx        <= '0;
                        dut_x      <= code_of(3'd0);
                        settle_cnt <= CW'(SETTLE_CYCLES);
                        state      <= SETTLE;
                    end else begin
                        // pass is resolved here so it is valid alongside the done pulse.
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        dut_x <= '0;
                        pass  <= (err_after_c == 8'd0);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_or3_sweep_tester.sv
// Bench for or3_sweep_tester: four differently configured testers, each driving
// a modelled gate-under-test, checked every cycle against a run-time model.
module tb_or3_sweep_tester;

    localparam int unsigned S_P [4] = '{2, 2, 2, 1};
    localparam int unsigned P_P [4] = '{1, 3, 1, 38};
    localparam bit          G_P [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam bit          I_P [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    logic       clk;
    logic [3:0] rst_n, start, abort;
    logic [2:0] dut_x [4];
    logic       dut_y [4];
    logic [3:0] busy, done, pass;
    logic [7:0] fail_mask [4];
    logic [7:0] err_count [4];

    // GUT behaviour: 0 ideal OR, 1 stuck 0, 2 z on code 5, 3 ideal NOR, 4 stuck 1
    int fmode [4] = '{0, 1, 3, 4};

    int  total = 0;
    int  bad   = 0;
    bit  chk_en = 1'b0;

    int          m_t    [4] = '{0, 0, 0, 0};
    bit          m_run  [4] = '{0, 0, 0, 0};
    logic [7:0]  m_mask [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
    logic [7:0]  m_err  [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
    logic        m_pass [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

    logic [2:0]  q2 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic gut_y(input int m, input logic [2:0] c);
        case (m)
            0:       return |c;
            1:       return 1'b0;
            2:       return (c == 3'd5) ? 1'bz : |c;
            3:       return ~(|c);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic ideal(input int i, input logic [2:0] c);
        return I_P[i] ? ~(|c) : (|c);
    endfunction

    function automatic int run_len(input int i);
        return 8 * int'(P_P[i]) * (int'(S_P[i]) + 1);
    endfunction

    // Code on dut_x during cycle t (t=1 is the first cycle after the start edge).
    function automatic logic [2:0] code_at(input int i, input int t);
        int pos;
        pos = ((t - 1) / (int'(S_P[i]) + 1)) % 8;
        return G_P[i] ? 3'(pos ^ (pos >> 1)) : 3'(pos);
    endfunction

    assign dut_y[0] = gut_y(fmode[0], dut_x[0]);
    assign dut_y[1] = gut_y(fmode[1], dut_x[1]);
    assign dut_y[2] = gut_y(fmode[2], dut_x[2]);
    assign dut_y[3] = gut_y(fmode[3], dut_x[3]);

    or3_sweep_tester #(.SETTLE_CYCLES(2), .PASSES(1), .ORDER("binary"), .INVERT(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .abort(abort[0]), .dut_x(dut_x[0]),
        .dut_y(dut_y[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .fail_mask(fail_mask[0]), .err_count(err_count[0]));
    or3_sweep_tester #(.SETTLE_CYCLES(2), .PASSES(3), .ORDER("binary"), .INVERT(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .abort(abort[1]), .dut_x(dut_x[1]),
        .dut_y(dut_y[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .fail_mask(fail_mask[1]), .err_count(err_count[1]));
    or3_sweep_tester #(.SETTLE_CYCLES(2), .PASSES(1), .ORDER("gray"), .INVERT(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .abort(abort[2]), .dut_x(dut_x[2]),
        .dut_y(dut_y[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .fail_mask(fail_mask[2]), .err_count(err_count[2]));
    or3_sweep_tester #(.SETTLE_CYCLES(1), .PASSES(38), .ORDER("binary"), .INVERT(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n[3]), .start(start[3]), .abort(abort[3]), .dut_x(dut_x[3]),
        .dut_y(dut_y[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
        .fail_mask(fail_mask[3]), .err_count(err_count[3]));

    task automatic check(input string name, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s u%0d: got %0h, want %0h (t=%0t)", name, i, act, exp, $time);
        end
    endtask

    // Run-level model: position in the run is a cycle count since the start edge.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            int         t;
            int         len;
            bit         run;
            logic [7:0] mk;
            logic [7:0] er;
            logic       ps;
            logic [2:0] c;
            t = m_t[i]; run = m_run[i]; mk = m_mask[i]; er = m_err[i]; ps = m_pass[i];
            len = run_len(i);
            if (!rst_n[i]) begin
                run = 1'b0; t = 0; mk = '0; er = '0; ps = 1'b0;
            end else if (run) begin
                if (abort[i]) begin
                    run = 1'b0; ps = 1'b0;
                end else begin
                    if (t <= len && (t % (int'(S_P[i]) + 1)) == 0) begin
                        c = code_at(i, t);
                        if (gut_y(fmode[i], c) !== ideal(i, c)) begin
                            mk[c] = 1'b1;
                            if (er != 8'd255) er = er + 8'd1;
                        end
                    end
                    t = t + 1;
                    if (t == len + 1) ps = (er == 8'd0);
                    else if (t == len + 2) run = 1'b0;
                end
            end else if (start[i] && !abort[i]) begin
                run = 1'b1; t = 1; mk = '0; er = '0; ps = 1'b0;
            end
            m_t[i] <= t; m_run[i] <= run; m_mask[i] <= mk; m_err[i] <= er; m_pass[i] <= ps;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                int   len;
                logic eb;
                logic ed;
                len = run_len(i);
                eb  = m_run[i] && (m_t[i] <= len);
                ed  = m_run[i] && (m_t[i] == len + 1);
                check("busy", i, 32'(busy[i]), 32'(eb));
                check("done", i, 32'(done[i]), 32'(ed));
                check("dut_x", i, 32'(dut_x[i]), eb ? 32'(code_at(i, m_t[i])) : 32'd0);
                check("pass", i, 32'(pass[i]), 32'(m_pass[i]));
                check("fail_mask", i, 32'(fail_mask[i]), 32'(m_mask[i]));
                check("err_count", i, 32'(err_count[i]), 32'(m_err[i]));
            end
        end
        if (busy[2]) q2.push_back(dut_x[2]);
    end

    task automatic wait_done(input int i, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[i] && n < budget);
        if (!done[i]) begin
            total++;
            bad++;
            $display("FAIL wait_done u%0d: no done within %0d cycles", i, budget);
        end
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk) start[i] = 1'b1;
        @(negedge clk) start[i] = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        logic [2:0] gray_lit [8];
        gray_lit = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
        rst_n = '0; start = '0; abort = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rst_busy", i, 32'(busy[i]), 32'd0);
            check("rst_err", i, 32'(err_count[i]), 32'd0);
        end
        rst_n = '1;

        // ideal OR on u0; u1..u3 run their long sweeps in the background
        @(negedge clk) start = '1;
        @(negedge clk) start = '0;
        wait_done(0, 60, n);
        check("t1_latency", 0, 32'(n + 1), 32'd25);
        check("t1_pass", 0, 32'(pass[0]), 32'd1);
        check("t1_mask", 0, 32'(fail_mask[0]), 32'h00);
        check("t1_err", 0, 32'(err_count[0]), 32'd0);

        // stuck-at-0
        @(negedge clk) fmode[0] = 1;
        pulse_start(0);
        wait_done(0, 60, n);
        check("t2_mask", 0, 32'(fail_mask[0]), 32'hFE);
        check("t2_err", 0, 32'(err_count[0]), 32'd7);
        check("t2_pass", 0, 32'(pass[0]), 32'd0);

        // z only on code 5
        @(negedge clk) fmode[0] = 2;
        pulse_start(0);
        wait_done(0, 60, n);
        check("t3_mask", 0, 32'(fail_mask[0]), 32'h20);
        check("t3_err", 0, 32'(err_count[0]), 32'd1);
        check("t3_pass", 0, 32'(pass[0]), 32'd0);

        // abort in cycle k+10 after samples of codes 0,1,2 (stuck-at-0)
        @(negedge clk) fmode[0] = 1;
        pulse_start(0);
        repeat (9) @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk) abort[0] = 1'b0;
        check("ab_busy", 0, 32'(busy[0]), 32'd0);
        check("ab_dut_x", 0, 32'(dut_x[0]), 32'd0);
        check("ab_err", 0, 32'(err_count[0]), 32'd2);
        check("ab_mask", 0, 32'(fail_mask[0]), 32'h06);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done[0]) seen++;
        end
        check("ab_no_done", 0, 32'(seen), 32'd0);

        // new start clears results; start held high must not restart the run
        fmode[0] = 0;
        start[0] = 1'b1;
        @(negedge clk);
        check("rs_mask", 0, 32'(fail_mask[0]), 32'h00);
        check("rs_err", 0, 32'(err_count[0]), 32'd0);
        wait_done(0, 60, n);
        start[0] = 1'b0;
        check("held_latency", 0, 32'(n + 1), 32'd25);
        check("held_pass", 0, 32'(pass[0]), 32'd1);

        // reset mid-run
        @(negedge clk) fmode[0] = 1;
        pulse_start(0);
        repeat (8) @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk) rst_n[0] = 1'b1;
        check("mr_busy", 0, 32'(busy[0]), 32'd0);
        check("mr_dut_x", 0, 32'(dut_x[0]), 32'd0);
        check("mr_err", 0, 32'(err_count[0]), 32'd0);
        check("mr_mask", 0, 32'(fail_mask[0]), 32'h00);
        check("mr_pass", 0, 32'(pass[0]), 32'd0);

        // background results
        check("p3_err", 1, 32'(err_count[1]), 32'd21);
        check("p3_mask", 1, 32'(fail_mask[1]), 32'hFE);
        check("p3_pass", 1, 32'(pass[1]), 32'd0);
        check("gray_pass", 2, 32'(pass[2]), 32'd1);
        check("gray_err", 2, 32'(err_count[2]), 32'd0);
        check("gray_len", 2, 32'(q2.size()), 32'd24);
        seen = 0;
        for (int j = 0; j < q2.size() && j < 24; j++) begin
            if (q2[j] !== gray_lit[j / 3]) seen++;
            if (j > 0 && (j % 3) == 0 && $countones(q2[j] ^ q2[j - 1]) != 1) seen++;
        end
        check("gray_seq", 2, 32'(seen), 32'd0);

        wait_done(3, 1000, n);
        check("sat_err", 3, 32'(err_count[3]), 32'd255);
        check("sat_mask", 3, 32'(fail_mask[3]), 32'hFE);
        check("sat_pass", 3, 32'(pass[3]), 32'd0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
